// File: rtl/tank_gfx_pkg.sv
// Shared types and widths for the tank graphics pipeline.
package tank_gfx_pkg;

    localparam int unsigned PAL_IDX_W   = 8;
    localparam int unsigned COMP_W      = 4;
    localparam int unsigned RGB_W       = 3 * COMP_W;
    localparam int unsigned BURST_CNT_W = 8;

    typedef logic [PAL_IDX_W-1:0] pal_idx_t;
    typedef logic [RGB_W-1:0]     rgb12_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping to 0.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               found
);

    logic [PTR_W:0]   cand_sum;
    logic [PTR_W-1:0] cand_idx;

    // Scan requesters in rotated order; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_sum = (PTR_W+1)'(ptr) + (PTR_W+1)'(k);
            if (cand_sum >= (PTR_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
            end
            cand_idx = cand_sum[PTR_W-1:0];
            if (!found && valid[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant[grant_idx] = found;
    end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one palette ROM among NUM_REQ requesters.
module palette_lookup_arbiter
    import tank_gfx_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned TRANSP_IDX = 0
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [NUM_REQ*PAL_IDX_W-1:0]   req_index,
    output logic [NUM_REQ-1:0]             req_ready,
    output pal_idx_t                       pal_index,
    input  logic [COMP_W-1:0]              pal_red,
    input  logic [COMP_W-1:0]              pal_green,
    input  logic [COMP_W-1:0]              pal_blue,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output rgb12_t                         rsp_rgb,
    output logic                           rsp_transp,
    output logic                           busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    arb_state_e             state, state_n;
    logic [PTR_W-1:0]       ptr, ptr_n;
    logic [PTR_W-1:0]       owner, owner_n;
    logic [BURST_CNT_W-1:0] count, count_n;
    logic [BURST_CNT_W:0]   cnt_inc;

    logic [NUM_REQ-1:0]     pick_oh;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_found;

    logic [NUM_REQ-1:0]     grant_oh;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_any;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .valid     (req_valid),
        .ptr       (ptr),
        .grant     (pick_oh),
        .grant_idx (pick_idx),
        .found     (pick_found)
    );

    // State, pointer and burst bookkeeping registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ARB_IDLE;
            ptr   <= '0;
            owner <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            count <= count_n;
        end
    end

    // Grant selection and next-state: IDLE arbitrates, BURST serves the owner only.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        count_n   = count;
        grant_oh  = '0;
        grant_idx = pick_idx;
        grant_any = 1'b0;
        cnt_inc   = {1'b0, count} + (BURST_CNT_W+1)'(1);
        case (state)
            ARB_IDLE: begin
                grant_oh  = pick_oh;
                grant_any = pick_found;
                if (pick_found) begin
                    if (!req_last[pick_idx] && (MAX_BURST > 1)) begin
                        state_n = ARB_BURST;
                        owner_n = pick_idx;
                        count_n = BURST_CNT_W'(1);
                    end else begin
                        ptr_n = wrap_inc(pick_idx);
                    end
                end
            end
            ARB_BURST: begin
                grant_idx = owner;
                if (req_valid[owner]) begin
                    grant_oh[owner] = 1'b1;
                    grant_any       = 1'b1;
                    if (req_last[owner] || (cnt_inc >= (BURST_CNT_W+1)'(MAX_BURST))) begin
                        state_n = ARB_IDLE;
                        ptr_n   = wrap_inc(owner);
                        count_n = '0;
                    end else begin
                        count_n = cnt_inc[BURST_CNT_W-1:0];
                    end
                end else begin
                    // Owner withdrew: spend this cycle leaving the burst, arbitrate next cycle.
                    state_n = ARB_IDLE;
                    ptr_n   = wrap_inc(owner);
                    count_n = '0;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    // ROM index follows the granted requester, parked at 0 otherwise.
    always_comb begin
        pal_index = '0;
        if (grant_any) begin
            pal_index = req_index[grant_idx*PAL_IDX_W +: PAL_IDX_W];
        end
    end

    assign req_ready = grant_oh;
    assign busy      = (state == ARB_BURST);

    // Capture the ROM colour one cycle after the grant, tagged to the granted requester.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid  <= '0;
            rsp_rgb    <= '0;
            rsp_transp <= 1'b0;
        end else begin
            rsp_valid  <= grant_oh;
            rsp_rgb    <= grant_any ? {pal_red, pal_green, pal_blue} : '0;
            rsp_transp <= grant_any && (pal_index == PAL_IDX_W'(TRANSP_IDX));
        end
    end

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed and randomized checks of palette_lookup_arbiter with a turret palette model.
module tb_palette_lookup_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned BOUND     = (NUM_REQ - 1) * MAX_BURST + 1;

    logic                   Clk;
    logic                   Reset_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ*8-1:0]   req_index;
    logic [NUM_REQ-1:0]     req_ready;
    logic [7:0]             pal_index;
    logic [3:0]             pal_red, pal_green, pal_blue;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [11:0]            rsp_rgb;
    logic                   rsp_transp;
    logic                   busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Turret palette: index 0 black (transparent), 5 white, others a fixed scramble.
    function automatic logic [11:0] turret3_palette(input logic [7:0] idx);
        case (idx)
            8'h00:   return 12'h000;
            8'h05:   return 12'hFFF;
            default: return {idx[3:0], idx[7:4], idx[3:0] ^ idx[7:4]};
        endcase
    endfunction

    assign {pal_red, pal_green, pal_blue} = turret3_palette(pal_index);

    palette_lookup_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .MAX_BURST  (MAX_BURST),
        .TRANSP_IDX (0)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_index  (req_index),
        .req_ready  (req_ready),
        .pal_index  (pal_index),
        .pal_red    (pal_red),
        .pal_green  (pal_green),
        .pal_blue   (pal_blue),
        .rsp_valid  (rsp_valid),
        .rsp_rgb    (rsp_rgb),
        .rsp_transp (rsp_transp),
        .busy       (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_index = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_index = '0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_rgb, rsp_transp, req_ready, busy, pal_index} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rsp_valid=%b rgb=%h transp=%b ready=%b busy=%b idx=%h, want all zero",
                     rsp_valid, rsp_rgb, rsp_transp, req_ready, busy, pal_index);
        end
        do_reset();
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        req_index = 32'h0000_0005;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        n_checks++;
        if (pal_index !== 8'h05) begin
            n_fail++; $display("FAIL single_pal_index: got %h want 05", pal_index);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_rgb !== 12'hFFF || rsp_transp !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp: got valid=%b rgb=%h transp=%b want 0001/FFF/0", rsp_valid, rsp_rgb, rsp_transp);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL single_rsp_one_cycle: got %b want 0000", rsp_valid);
        end
    endtask

    task automatic test_idle_hold();
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000 || pal_index !== 8'h00) begin
                n_fail++; $display("FAIL idle_no_grant: got ready=%b idx=%h want 0000/00", req_ready, pal_index);
            end
            tick();
        end
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL idle_ptr_held: got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_index = 32'h0000_0000;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            #1;
            n_checks++;
            if (req_ready !== exp_g) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_g);
            end
            tick();
            n_checks++;
            if (rsp_valid !== exp_g || rsp_transp !== 1'b1 || rsp_rgb !== 12'h000) begin
                n_fail++;
                $display("FAIL rr_rsp[%0d]: got valid=%b transp=%b rgb=%h want %b/1/000", k, rsp_valid, rsp_transp, rsp_rgb, exp_g);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_burst_limit();
        logic [3:0] exp_g   [10] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001,
                                     4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        logic       exp_b   [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                     1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] exp_idx;
        req_index = 32'h0012_0034;
        req_valid = 4'b0101;
        req_last  = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            exp_idx = (exp_g[k] == 4'b0100) ? 8'h12 : 8'h34;
            #1;
            n_checks++;
            if (req_ready !== exp_g[k] || busy !== exp_b[k] || pal_index !== exp_idx) begin
                n_fail++;
                $display("FAIL burst_grant[%0d]: got ready=%b busy=%b idx=%h want %b/%b/%h",
                         k, req_ready, busy, pal_index, exp_g[k], exp_b[k], exp_idx);
            end
            tick();
            n_checks++;
            if (rsp_valid !== exp_g[k] || rsp_rgb !== turret3_palette(exp_idx)) begin
                n_fail++;
                $display("FAIL burst_rsp[%0d]: got valid=%b rgb=%h want %b/%h", k, rsp_valid, rsp_rgb,
                         exp_g[k], turret3_palette(exp_idx));
            end
        end
        req_valid = '0;
    endtask

    task automatic test_single_rotation();
        logic exp_b [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        req_index = 32'h4200_0000;
        for (int k = 0; k < 9; k++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b1000 || busy !== exp_b[k]) begin
                n_fail++;
                $display("FAIL rotate_regrant[%0d]: got ready=%b busy=%b want 1000/%b", k, req_ready, busy, exp_b[k]);
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_owner_drop();
        logic [3:0] exp_g [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010};
        logic       exp_b [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        req_index = 32'h0000_0708;
        req_last  = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            req_valid = (k < 2) ? 4'b0011 : 4'b0010;
            #1;
            n_checks++;
            if (req_ready !== exp_g[k] || busy !== exp_b[k]) begin
                n_fail++;
                $display("FAIL drop_grant[%0d]: got ready=%b busy=%b want %b/%b", k, req_ready, busy, exp_g[k], exp_b[k]);
            end
            tick();
            n_checks++;
            if (rsp_valid !== exp_g[k]) begin
                n_fail++; $display("FAIL drop_rsp[%0d]: got %b want %b", k, rsp_valid, exp_g[k]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0100;
        req_last  = 4'b0100;
        req_index = 32'h0005_0000;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL rstmid_grant: got %b want 0100", req_ready);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 4'b0100) begin
            n_fail++; $display("FAIL rstmid_pre_rsp: got %b want 0100", rsp_valid);
        end
        Reset_n   = 1'b0;
        req_valid = '0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_rgb, rsp_transp, req_ready, busy, pal_index} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got rsp_valid=%b rgb=%h transp=%b ready=%b busy=%b idx=%h, want all zero",
                     rsp_valid, rsp_rgb, rsp_transp, req_ready, busy, pal_index);
        end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n   = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rstmid_first_grant: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] pend;
        logic [NUM_REQ-1:0] last_r;
        logic [7:0]         idx_r  [NUM_REQ];
        int                 wait_c [NUM_REQ];
        logic [3:0]         rr, exp_rsp;
        logic [11:0]        exp_rgb;
        logic               exp_tr;
        int                 g;
        do_reset();
        pend   = '0;
        last_r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_r[i]  = 8'h00;
            wait_c[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_index[8*i +: 8] = idx_r[i];
            end
            req_valid = pend;
            req_last  = last_r;
            #1;
            rr = req_ready;
            n_checks++;
            if ($countones(rr) > 1 || (rr & ~pend) != 4'b0000) begin
                n_fail++; $display("FAIL rand_onehot[%0d]: ready=%b valid=%b", c, rr, pend);
            end
            g = -1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rr[i]) g = i;
            end
            exp_rsp = rr;
            exp_rgb = 12'h000;
            exp_tr  = 1'b0;
            if (g >= 0) begin
                exp_rgb = turret3_palette(idx_r[g]);
                exp_tr  = (idx_r[g] == 8'h00);
                n_checks++;
                if (pal_index !== idx_r[g]) begin
                    n_fail++; $display("FAIL rand_pal_index[%0d]: got %h want %h", c, pal_index, idx_r[g]);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pend[i]) wait_c[i]++;
                if (i == g) begin
                    n_checks++;
                    if (wait_c[i] > int'(BOUND)) begin
                        n_fail++; $display("FAIL rand_wait[%0d] req%0d: waited %0d want <= %0d", c, i, wait_c[i], BOUND);
                    end
                    wait_c[i] = 0;
                end
            end
            tick();
            n_checks++;
            if (rsp_valid !== exp_rsp || rsp_rgb !== exp_rgb || rsp_transp !== exp_tr) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: got %b/%h/%b want %b/%h/%b", c, rsp_valid, rsp_rgb, rsp_transp,
                         exp_rsp, exp_rgb, exp_tr);
            end
            // Requesters hold valid until a final beat is consumed, so bursts never stall.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == g && last_r[i]) pend[i] = ($urandom_range(0, 1) == 1);
                else if (!pend[i])       pend[i] = ($urandom_range(0, 2) == 0);
                last_r[i] = ($urandom_range(0, 2) == 0);
                idx_r[i]  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            n_checks++;
            if (wait_c[i] > int'(BOUND)) begin
                n_fail++; $display("FAIL rand_final_wait req%0d: waited %0d want <= %0d", i, wait_c[i], BOUND);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        Reset_n   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_index = '0;
        test_reset();
        test_single();
        test_idle_hold();
        test_round_robin();
        test_burst_limit();
        test_single_rotation();
        test_owner_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
